// File: rtl/sentinel_key_presenter_if.sv
// rtl/sentinel_key_presenter_if.sv - signal bundle between the key presenter, its controller and the gate
//
// Purpose: groups the provisioning handshake and the gate pin signals so the
// presenter and its environment connect through one port.
// Signals:
//   start      controller -> presenter, one-cycle run request
//   seg_in     gate -> presenter, 7-seg code (active low)
//   glow_in    gate -> presenter, status array
//   key_out    presenter -> gate, key bus
//   gate_rst_n presenter -> gate, reset (active low)
//   gate_ena   presenter -> gate, enable
//   busy       presenter -> controller, sequence in progress
//   done       presenter -> controller, one-cycle completion pulse
//   result     presenter -> controller, outcome code
//   attempts   presenter -> controller, attempts used by the last sequence
// Modports: master = presenter side, slave = controller/gate side.

interface sentinel_key_presenter_if;
    logic       start;
    logic [7:0] seg_in;
    logic [7:0] glow_in;
    logic [7:0] key_out;
    logic       gate_rst_n;
    logic       gate_ena;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [3:0] attempts;

    modport master (
        input  start, seg_in, glow_in,
        output key_out, gate_rst_n, gate_ena, busy, done, result, attempts
    );

    modport slave (
        output start, seg_in, glow_in,
        input  key_out, gate_rst_n, gate_ena, busy, done, result, attempts
    );
endinterface

// File: rtl/sentinel_key_presenter.sv
// rtl/sentinel_key_presenter.sv - sequences a Sentinel Lock gate and presents the authorization key
//
// Purpose: on start, resets the gate, waits for LOCKED, drives KEY and watches
// for VERIFIED; retries on timeout, aborts on hard-lock/tamper codes and
// reports one result with a done pulse.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  sentinel_key_presenter_if.master (start, seg_in, glow_in in;
//        key_out, gate_rst_n, gate_ena, busy, done, result, attempts out)

module sentinel_key_presenter #(
    parameter logic [7:0]  KEY          = 8'hB6,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    sentinel_key_presenter_if.master bus
);

    localparam logic [7:0] SEG_LOCKED   = 8'hC7;
    localparam logic [7:0] SEG_VERIFIED = 8'hC1;
    localparam logic [7:0] SEG_HARD     = 8'hC9;
    localparam logic [7:0] SEG_OFF      = 8'hFF;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_GRANTED = 2'b01;
    localparam logic [1:0] RES_HARD    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    // The setup window is measured at the registered seg copy, which trails the
    // gate by one cycle, so SETUP may run for SETUP_CYCLES+1 decisions.
    localparam logic [7:0] SETUP_LIM = 8'(SETUP_CYCLES);
    // The key is held for exactly HOLD_CYCLES cycles, timer values 0..HOLD_CYCLES-1.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [4:0] RETRY_LIM = 5'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        GATE_RST,
        SETUP,
        PRESENT,
        RETRY,
        REPORT
    } state_t;

    state_t     state, state_d;
    logic [7:0] seg_q, glow_q;
    logic [7:0] tmr, tmr_d;
    logic       pair_seen, pair_d;
    logic [3:0] attempts_q, attempts_d;
    logic [1:0] result_q, result_d;
    logic       ena_q, ena_d;

    logic pair_ok;
    logic fault;

    assign pair_ok = (seg_q == SEG_VERIFIED) && (glow_q == 8'hFF);
    // Anything other than LOCKED, VERIFIED or disabled is treated as hard-lock/tamper.
    assign fault   = (seg_q != SEG_LOCKED) && (seg_q != SEG_VERIFIED) && (seg_q != SEG_OFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            seg_q      <= SEG_OFF;
            glow_q     <= 8'h00;
            tmr        <= 8'h00;
            pair_seen  <= 1'b0;
            attempts_q <= 4'h0;
            result_q   <= RES_NONE;
            ena_q      <= 1'b0;
        end else begin
            state      <= state_d;
            seg_q      <= bus.seg_in;
            glow_q     <= bus.glow_in;
            tmr        <= tmr_d;
            pair_seen  <= pair_d;
            attempts_q <= attempts_d;
            result_q   <= result_d;
            ena_q      <= ena_d;
        end
    end

    always_comb begin
        state_d    = state;
        tmr_d      = tmr;
        pair_d     = pair_seen;
        attempts_d = attempts_q;
        result_d   = result_q;
        ena_d      = ena_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d    = GATE_RST;
                    tmr_d      = 8'h00;
                    attempts_d = 4'h1;
                    result_d   = RES_NONE;
                    ena_d      = 1'b1;
                end
            end

            GATE_RST: begin
                if (tmr == 8'h01) begin
                    state_d = SETUP;
                    tmr_d   = 8'h00;
                end else begin
                    tmr_d = tmr + 8'h01;
                end
            end

            SETUP: begin
                if (tmr != SETUP_LIM) begin
                    tmr_d = tmr + 8'h01;
                end
                if (seg_q == SEG_LOCKED) begin
                    state_d = PRESENT;
                    tmr_d   = 8'h00;
                    pair_d  = 1'b0;
                end else if ((seg_q == SEG_HARD) || (tmr == SETUP_LIM)) begin
                    state_d = RETRY;
                    tmr_d   = 8'h00;
                end
            end

            PRESENT: begin
                if (tmr != HOLD_LAST) begin
                    tmr_d = tmr + 8'h01;
                end
                // Any sample that is not a full VERIFIED pair breaks the run.
                pair_d = pair_ok;
                if (fault) begin
                    state_d  = REPORT;
                    tmr_d    = 8'h00;
                    result_d = RES_HARD;
                end else if (pair_ok && pair_seen) begin
                    state_d  = REPORT;
                    tmr_d    = 8'h00;
                    result_d = RES_GRANTED;
                end else if (tmr == HOLD_LAST) begin
                    state_d = RETRY;
                    tmr_d   = 8'h00;
                end
            end

            RETRY: begin
                tmr_d = 8'h00;
                if ({1'b0, attempts_q} <= RETRY_LIM) begin
                    state_d    = GATE_RST;
                    attempts_d = (attempts_q == 4'hF) ? attempts_q : attempts_q + 4'h1;
                end else begin
                    state_d  = REPORT;
                    result_d = RES_TIMEOUT;
                end
            end

            REPORT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_out    = (state == PRESENT) ? KEY : 8'h00;
    assign bus.gate_rst_n = (state != GATE_RST);
    assign bus.gate_ena   = ena_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == REPORT);
    assign bus.result     = result_q;
    assign bus.attempts   = attempts_q;

endmodule
